// File: rtl/csa_bist_engine.sv
// csa_bist_engine: built-in self-test engine for a WIDTH-bit carry-select adder.
// It issues {x,y} operand pairs, either exhaustively or from an LFSR, and drives
// the golden sums {x+y+1, x+y}. After DUT_LAT clocks it checks the DUT response,
// counts mismatches and records the ordinal of the first failing pattern.
// Ports:
//   clk, init (async active-high reset)
//   test (advance enable), start (run request), mode (0 exhaustive, 1 LFSR)
//   test_data / desired_output (to DUT), dut_resp (from DUT)
//   busy, done, pass, err_count, first_fail_idx (status to the controller)
module csa_bist_engine #(
   parameter int          WIDTH     = 4,
   parameter int          DUT_LAT   = 1,
   parameter logic [15:0] LFSR_TAPS = 16'h00B8,
   parameter int          ERR_W     = 16
) (
   input  logic                 clk,
   input  logic                 init,
   input  logic                 test,
   input  logic                 start,
   input  logic                 mode,
   output logic [2*WIDTH-1:0]   test_data,
   output logic [2*WIDTH+1:0]   desired_output,
   input  logic [2*WIDTH+1:0]   dut_resp,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_W-1:0]     err_count,
   output logic [2*WIDTH-1:0]   first_fail_idx
);

   localparam int PW = 2 * WIDTH;
   localparam int OW = PW + 2;
   localparam int CW = PW + 1;
   localparam int PD = (DUT_LAT > 0) ? DUT_LAT : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Ordinal of the final issue for each pattern source.
   localparam logic [CW-1:0] EXH_LAST  = CW'((1 << PW) - 1);
   localparam logic [CW-1:0] LFSR_LAST = CW'((1 << PW) - 2);
   localparam logic [3:0]    DRN_LAST  = 4'(DUT_LAT - 1);

   logic [1:0]       r_state;
   logic [PW-1:0]    r_pat;
   logic             r_mode;
   logic [CW-1:0]    r_cnt;
   logic [3:0]       r_drain;
   logic [ERR_W-1:0] r_err;
   logic [PW-1:0]    r_ffi;
   logic             r_seen;

   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic [WIDTH:0]   w_sum0;
   logic [WIDTH:0]   w_sum1;
   logic             w_issue;
   logic             w_last;
   logic             w_fb;
   logic [PW-1:0]    w_next;
   logic             w_start;
   logic             w_cv;
   logic [OW-1:0]    w_ce;
   logic [PW-1:0]    w_ci;
   logic             w_miss;

   assign w_x    = r_pat[PW-1:WIDTH];
   assign w_y    = r_pat[WIDTH-1:0];
   assign w_sum0 = {1'b0, w_x} + {1'b0, w_y};
   // x+y+1 peaks at 2^(WIDTH+1)-1, so WIDTH+1 bits never overflow.
   assign w_sum1 = w_sum0 + 1'b1;

   assign test_data      = r_pat;
   assign desired_output = {w_sum1, w_sum0};

   assign w_issue = (r_state == S_RUN) && test;
   assign w_last  = w_issue &&
                    (r_cnt == (r_mode ? LFSR_LAST : EXH_LAST));
   assign w_fb    = ^(r_pat & LFSR_TAPS[PW-1:0]);
   assign w_next  = r_mode ? {r_pat[PW-2:0], w_fb}
                           : r_pat + 1'b1;
   assign w_start = start &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));

   // Expected value and ordinal travel alongside the DUT latency.
   generate
      if (DUT_LAT > 0) begin : g_pipe
         logic [PD-1:0] r_pv;
         logic [OW-1:0] r_pe [PD];
         logic [PW-1:0] r_pi [PD];

         always_ff @(posedge clk or posedge init) begin
            if (init) begin
               r_pv <= '0;
               for (int i = 0; i < PD; i++) begin
                  r_pe[i] <= '0;
                  r_pi[i] <= '0;
               end
            end else begin
               r_pv[0] <= w_issue;
               r_pe[0] <= desired_output;
               r_pi[0] <= r_cnt[PW-1:0];
               for (int i = 1; i < PD; i++) begin
                  r_pv[i] <= r_pv[i-1];
                  r_pe[i] <= r_pe[i-1];
                  r_pi[i] <= r_pi[i-1];
               end
            end
         end

         assign w_cv = r_pv[PD-1];
         assign w_ce = r_pe[PD-1];
         assign w_ci = r_pi[PD-1];
      end else begin : g_nopipe
         assign w_cv = w_issue;
         assign w_ce = desired_output;
         assign w_ci = r_cnt[PW-1:0];
      end
   endgenerate

   assign w_miss = w_cv && (dut_resp != w_ce);

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         r_state <= S_IDLE;
         r_pat   <= '0;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
         r_drain <= '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_mode  <= mode;
                  r_pat   <= mode ? PW'(1) : '0;
                  r_cnt   <= '0;
                  r_drain <= '0;
               end
            end
            S_RUN: begin
               if (test) begin
                  r_pat <= w_next;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_state <= (DUT_LAT > 0) ? S_DRAIN : S_DONE;
                     r_drain <= '0;
                  end
               end
            end
            S_DRAIN: begin
               if (r_drain == DRN_LAST)
                  r_state <= S_DONE;
               else
                  r_drain <= r_drain + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The pipe is empty whenever start is accepted, so a clear
   // never races with a pending compare.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         r_err  <= '0;
         r_ffi  <= '0;
         r_seen <= 1'b0;
      end else if (w_start) begin
         r_err  <= '0;
         r_ffi  <= '0;
         r_seen <= 1'b0;
      end else if (w_miss) begin
         if (r_err != '1)
            r_err <= r_err + 1'b1;
         if (!r_seen) begin
            r_ffi  <= w_ci;
            r_seen <= 1'b1;
         end
      end
   end

   assign busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done           = (r_state == S_DONE);
   assign pass           = done && (r_err == '0);
   assign err_count      = r_err;
   assign first_fail_idx = r_ffi;

endmodule
